cleared_dual_port_ram: RTL and testbench

Single-clock simple dual-port RAM (one write port, one read port) with a built-in clear sequencer that sweeps every location to a fill value after reset or on request. It replaces the earlier dual-clock RAM used for board and display storage. It adds:
- parametrised depth and fill value;
- read-valid signalling;
- write-first forwarding for same-address accesses;
- out-of-range protection.

---
 rtl/cdpr_pkg.sv | 12 +
 rtl/cdpr_clear_sequencer.sv | 67 ++++++
 rtl/cleared_dual_port_ram.sv | 120 ++++++++++++
 tb/tb_cleared_dual_port_ram.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdpr_pkg.sv
// Shared definitions for cleared_dual_port_ram: clear-sequencer FSM states
// and the default fill constant.
package cdpr_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } cdpr_state_e;

   localparam int unsigned CDPR_DEFAULT_FILL = 0;

endpackage

// File: rtl/cdpr_clear_sequencer.sv
// Clear sequencer: sweeps addresses 0..DEPTH-1 once per clear request (or
// after reset release when CLEAR_ON_RESET=1) and reports busy while sweeping.
module cdpr_clear_sequencer
   import cdpr_pkg::*;
#(
   parameter int ADDR_WIDTH     = 9,
   parameter int DEPTH          = 2 ** ADDR_WIDTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  clear_i,
   output logic [ADDR_WIDTH-1:0] sweep_addr_o,
   output logic                  sweep_we_o,
   output logic                  busy_o,
   output cdpr_state_e           state_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam cdpr_state_e           RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

   cdpr_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= RESET_STATE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // A clear request seen while already sweeping is ignored on purpose.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      sweep_we_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_i) begin
               state_d = CLEAR;
               count_d = '0;
            end
         end
         CLEAR: begin
            sweep_we_o = 1'b1;
            if (count_q == LAST_ADDR) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + ADDR_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   assign sweep_addr_o = count_q;
   assign busy_o       = (state_q == CLEAR);
   assign state_o      = state_q;

endmodule

// File: rtl/cleared_dual_port_ram.sv
// Single-clock simple dual-port RAM with a clear sweep, write-first forwarding
// and out-of-range protection. Define CDPR_OUT_REG_EN for a 2-cycle read path.
module cleared_dual_port_ram
   import cdpr_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 7,
   parameter int                    ADDR_WIDTH     = 9,
   parameter int                    DEPTH          = 2 ** ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = DATA_WIDTH'(CDPR_DEFAULT_FILL),
   parameter bit                    CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [ADDR_WIDTH-1:0] write_addr_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] read_addr_i,
   input  logic                  re_i,
   input  logic                  clear_i,
   output logic [DATA_WIDTH-1:0] q_o,
   output logic                  valid_o,
   output logic                  busy_o,
   output logic                  drop_o
);

   localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] sweep_addr;
   logic                  sweep_we;
   logic                  busy;
   cdpr_state_e           seq_state;

   cdpr_clear_sequencer #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_sequencer (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .clear_i      (clear_i),
      .sweep_addr_o (sweep_addr),
      .sweep_we_o   (sweep_we),
      .busy_o       (busy),
      .state_o      (seq_state)
   );

   logic wr_in_range, rd_in_range, wr_ok;

   assign wr_in_range = ({1'b0, write_addr_i} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, read_addr_i} < DEPTH_EXT);
   assign wr_ok       = we_i && (seq_state == IDLE) && wr_in_range;

   // Sweep and user writes are mutually exclusive: users only write in IDLE.
   always_ff @(posedge clock_i) begin
      if (sweep_we) begin
         mem[sweep_addr[IDX_W-1:0]] <= FILL_VALUE;
      end else if (wr_ok) begin
         mem[write_addr_i[IDX_W-1:0]] <= data_i;
      end
   end

   logic [DATA_WIDTH-1:0] rd_data;

   always_comb begin
      rd_data = mem[read_addr_i[IDX_W-1:0]];
      if (busy || !rd_in_range) begin
         rd_data = FILL_VALUE;
      end else if (wr_ok && (write_addr_i == read_addr_i)) begin
         rd_data = data_i;
      end
   end

   logic [DATA_WIDTH-1:0] rd_q;
   logic                  rd_valid_q;
   logic                  drop_q;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         rd_valid_q <= re_i;
         drop_q     <= we_i && !wr_ok;
         if (re_i) begin
            rd_q <= rd_data;
         end
      end
   end

`ifdef CDPR_OUT_REG_EN
   logic [DATA_WIDTH-1:0] out_q;
   logic                  out_valid_q;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= rd_valid_q;
         if (rd_valid_q) begin
            out_q <= rd_q;
         end
      end
   end

   assign q_o     = out_q;
   assign valid_o = out_valid_q;
`else
   assign q_o     = rd_q;
   assign valid_o = rd_valid_q;
`endif

   assign busy_o = busy;
   assign drop_o = drop_q;

endmodule

// File: tb/tb_cleared_dual_port_ram.sv
// Bench for cleared_dual_port_ram: two instances (16-deep auto-clear, 12-deep
// no auto-clear) driven by directed steps, with a read-result scoreboard.
module tb_cleared_dual_port_ram;

   localparam int LAT =
`ifdef CDPR_OUT_REG_EN
      2;
`else
      1;
`endif

   logic       clk;
   logic       rst   [2];
   logic [6:0] data  [2];
   logic [3:0] waddr [2];
   logic [3:0] raddr [2];
   logic       we    [2];
   logic       re    [2];
   logic       clr   [2];
   logic [6:0] q     [2];
   logic       valid [2];
   logic       busy  [2];
   logic       drop  [2];

   logic [6:0] model    [2][16];
   logic [1:0] hist     [2];
   logic       exp_drop [2];
   logic [6:0] exp_q0[$];
   logic [6:0] exp_q1[$];

   int checks = 0;
   int passed = 0;

   cleared_dual_port_ram #(
      .DATA_WIDTH(7), .ADDR_WIDTH(4), .DEPTH(16), .FILL_VALUE(7'h55), .CLEAR_ON_RESET(1'b1)
   ) dut_a (
      .clock_i(clk), .reset_i(rst[0]), .data_i(data[0]), .write_addr_i(waddr[0]),
      .we_i(we[0]), .read_addr_i(raddr[0]), .re_i(re[0]), .clear_i(clr[0]),
      .q_o(q[0]), .valid_o(valid[0]), .busy_o(busy[0]), .drop_o(drop[0])
   );

   cleared_dual_port_ram #(
      .DATA_WIDTH(7), .ADDR_WIDTH(4), .DEPTH(12), .FILL_VALUE(7'h33), .CLEAR_ON_RESET(1'b0)
   ) dut_b (
      .clock_i(clk), .reset_i(rst[1]), .data_i(data[1]), .write_addr_i(waddr[1]),
      .we_i(we[1]), .read_addr_i(raddr[1]), .re_i(re[1]), .clear_i(clr[1]),
      .q_o(q[1]), .valid_o(valid[1]), .busy_o(busy[1]), .drop_o(drop[1])
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] fill_of(input int d);
      return (d == 0) ? 7'h55 : 7'h33;
   endfunction

   function automatic int depth_of(input int d);
      return (d == 0) ? 16 : 12;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // driver tasks
   task automatic wr(input int d, input int a, input logic [6:0] v, input bit ok);
      we[d]       = 1'b1;
      waddr[d]    = 4'(a);
      data[d]     = v;
      exp_drop[d] = !ok;
      if (ok) model[d][a] = v;
   endtask

   task automatic rd(input int d, input int a, input bit busy_now);
      logic [6:0] e;
      re[d]    = 1'b1;
      raddr[d] = 4'(a);
      e = (busy_now || a >= depth_of(d)) ? fill_of(d) : model[d][a];
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic fill_model(input int d);
      for (int i = 0; i < 16; i++) model[d][i] = fill_of(d);
   endtask

   // one clock edge: scoreboard compare, then idle the inputs
   task automatic tick();
      logic       ev;
      logic [6:0] e;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         hist[d] = rst[d] ? 2'b00 : {hist[d][0], re[d]};
         ev = hist[d][LAT-1];
         chk($sformatf("valid%0d", d), valid[d], ev);
         chk($sformatf("drop%0d", d), drop[d], exp_drop[d]);
         if (ev) begin
            chk($sformatf("sb_nonempty%0d", d), (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0), 1);
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("q%0d", d), q[d], e);
         end
         we[d] = 1'b0; re[d] = 1'b0; clr[d] = 1'b0; exp_drop[d] = 1'b0;
      end
   endtask

   task automatic flush();
      repeat (2) tick();
   endtask

   initial begin
      int n;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; data[d] = '0; waddr[d] = '0; raddr[d] = '0;
         we[d] = 1'b0; re[d] = 1'b0; clr[d] = 1'b0;
         hist[d] = 2'b00; exp_drop[d] = 1'b0;
      end
      #1;
      chk("rst_q_a", q[0], 0);
      chk("rst_valid_a", valid[0], 0);
      chk("rst_drop_a", drop[0], 0);
      chk("rst_busy_a", busy[0], 1);
      chk("rst_busy_b", busy[1], 0);
      chk("rst_q_b", q[1], 0);
      repeat (2) tick();

      // auto-clear after reset: busy for exactly 16 edges
      rst[0] = 1'b0;
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (!busy[0]) break;
      end
      chk("auto_clear_len", n, 16);
      fill_model(0);
      for (int a = 0; a < 16; a++) begin
         rd(0, a, 0);
         tick();
      end
      flush();

      // write then read, then same-edge forwarding
      wr(0, 3, 7'h2A, 1); tick();
      rd(0, 3, 0); tick(); flush();
      wr(0, 5, 7'h11, 1); rd(0, 5, 0); tick();
      rd(0, 5, 0); tick(); flush();

      // clear with same-edge write, drop while busy, second clear ignored
      clr[0] = 1'b1; wr(0, 4, 7'h7F, 1); tick();
      chk("clear_busy_a", busy[0], 1);
      n = 0;
      while (n < 100) begin
         if (n == 0) wr(0, 7, 7'h66, 0);
         if (n == 5) clr[0] = 1'b1;
         if (n == 8) rd(0, 2, 1);
         tick();
         n++;
         if (!busy[0]) break;
      end
      chk("clear_len", n, 16);
      fill_model(0);
      wr(0, 9, 7'h12, 1); tick();
      rd(0, 9, 0); tick();
      rd(0, 7, 0); tick();
      rd(0, 4, 0); tick();
      rd(0, 3, 0); tick(); flush();

      // randomised write/read traffic
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 1)
            wr(0, int'($urandom_range(0, 15)), 7'($urandom_range(0, 127)), 1);
         rd(0, int'($urandom_range(0, 15)), 0);
         tick();
      end
      flush();

      // 12-deep instance: out-of-range protection
      rst[1] = 1'b0;
      tick();
      chk("idle_busy_b", busy[1], 0);
      wr(1, 13, 7'h01, 0); tick();
      rd(1, 13, 0); tick();
      wr(1, 11, 7'h44, 1); tick();
      wr(1, 12, 7'h22, 0); rd(1, 11, 0); tick(); flush();

      // reset in the middle of a sweep, no auto-clear
      clr[1] = 1'b1; tick();
      chk("clear_busy_b", busy[1], 1);
      repeat (4) tick();
      for (int i = 0; i < 4; i++) model[1][i] = 7'h33;
      #2 rst[1] = 1'b1;
      #1;
      chk("async_busy_b", busy[1], 0);
      chk("async_q_b", q[1], 0);
      chk("async_valid_b", valid[1], 0);
      tick();
      rst[1] = 1'b0;
      chk("post_rst_busy_b", busy[1], 0);
      wr(1, 2, 7'h15, 1); tick();
      rd(1, 2, 0); tick();
      rd(1, 0, 0); tick(); flush();

      chk("sb_drain_a", exp_q0.size(), 0);
      chk("sb_drain_b", exp_q1.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
